dmem_req_unit: RTL and testbench

DMEM_REQ_UNIT -- requirements
Module: dmem_req_unit

---
 rtl/dmem_req_unit_pkg.sv | 32 +++
 rtl/dmem_req_unit_store_align.sv | 25 ++
 rtl/dmem_req_unit.sv | 124 ++++++++++++
 tb/tb_dmem_req_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_req_unit_pkg.sv
// Shared types for the data-memory request unit: FSM states, load/store funct3 encodings
// and the misalignment predicate used when MISALIGN_TRAP_EN is defined.
package types;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } dmem_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // size is funct3[1:0]; the sign bit does not affect alignment
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size == LH[1:0]) begin
            mis = addr_lo[0];
        end else if (size == LW[1:0]) begin
            mis = (addr_lo != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/dmem_req_unit_store_align.sv
// Combinational store lane logic: byte-enable mask and lane-replicated write data
// derived from access size and the low address bits.
module store_align
    import types::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    output logic [3:0]  mask,
    output logic [31:0] wdata_out
);

    always_comb begin
        mask      = 4'b1111;
        wdata_out = wdata_in;
        if (size == SB[1:0]) begin
            mask      = 4'b0001 << addr_lo;
            wdata_out = {4{wdata_in[7:0]}};
        end else if (size == SH[1:0]) begin
            mask      = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_out = {2{wdata_in[15:0]}};
        end
    end

endmodule

// File: rtl/dmem_req_unit.sv
// Data-memory request unit: latches an EX/MEM load/store, holds the dmem request until the
// response, and presents the raw read word. MISALIGN_TRAP_EN enables the misaligned-access trap.
module dmem_req_unit
    import types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        pipe_advance,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] rdata_o,
    output logic        done,
    output logic        dside_stall_n,
    output logic        misalign
);

    dmem_state_t state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        load_q, load_d;
    logic        mis_q, mis_d;
    logic        req_mem, req_mis, accept, busy;
    logic [3:0]  lane_mask;
    logic        unused;

    assign req_mem = req_valid & (req_load | req_store);
    // Sign bit only matters to the consumer of rdata_o, not to the request itself
    assign unused  = ^{req_funct3[2], mis_q};

`ifdef MISALIGN_TRAP_EN
    assign req_mis  = is_misaligned(req_funct3[1:0], req_addr[1:0]);
    assign misalign = mis_q;
`else
    assign req_mis  = 1'b0;
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        size_d  = size_q;
        load_d  = load_q;
        mis_d   = mis_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: accept = req_mem;
            StBusy: begin
                if (dmem_resp) begin
                    state_d = StDone;
                    if (load_q) rdata_d = dmem_rdata;
                end
            end
            StDone: begin
                if (pipe_advance) begin
                    state_d = StIdle;
                    mis_d   = 1'b0;
                    accept  = req_mem;
                end
            end
            default: state_d = StIdle;
        endcase
        if (accept) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            size_d  = req_funct3[1:0];
            load_d  = req_load;
            mis_d   = req_mis;
            state_d = req_mis ? StDone : StBusy;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            load_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            load_q  <= load_d;
            mis_q   <= mis_d;
        end
    end

    store_align u_store_align (
        .size      (size_q),
        .addr_lo   (addr_q[1:0]),
        .wdata_in  (wdata_q),
        .mask      (lane_mask),
        .wdata_out (dmem_wdata)
    );

    assign busy          = (state_q == StBusy);
    assign dmem_read     = busy & load_q;
    assign dmem_write    = busy & ~load_q;
    assign dmem_address  = {addr_q[31:2], 2'b00};
    assign dmem_wmask    = dmem_write ? lane_mask : 4'b0000;
    assign rdata_o       = rdata_q;
    assign done          = (state_q == StDone);
    assign dside_stall_n = ~(busy | ((state_q == StIdle) & req_mem));

endmodule

// File: tb/tb_dmem_req_unit.sv
// Directed self-checking bench for dmem_req_unit; expected values are hand-computed.
module tb_dmem_req_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        pipe_advance, dmem_resp;
    logic [31:0] dmem_rdata;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata, rdata_o;
    logic [3:0]  dmem_wmask;
    logic        done, dside_stall_n, misalign;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    dmem_req_unit dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_load      (req_load),
        .req_store     (req_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .pipe_advance  (pipe_advance),
        .dmem_resp     (dmem_resp),
        .dmem_rdata    (dmem_rdata),
        .dmem_read     (dmem_read),
        .dmem_write    (dmem_write),
        .dmem_address  (dmem_address),
        .dmem_wdata    (dmem_wdata),
        .dmem_wmask    (dmem_wmask),
        .rdata_o       (rdata_o),
        .done          (done),
        .dside_stall_n (dside_stall_n),
        .misalign      (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
        req_valid  = 1'b1;
        req_load   = ld;
        req_store  = ~ld;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        #1;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_load  = 1'b0;
        req_store = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_req();
        req_funct3   = 3'b000;
        req_addr     = '0;
        req_wdata    = '0;
        pipe_advance = 1'b0;
        dmem_resp    = 1'b0;
        dmem_rdata   = '0;

        // Reset state
        cyc();
        cyc();
        chk("rst_read", {31'd0, dmem_read}, 0);
        chk("rst_write", {31'd0, dmem_write}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_addr", dmem_address, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_mask", {28'd0, dmem_wmask}, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_stall_n", {31'd0, dside_stall_n}, 1);
        chk("rst_misalign", {31'd0, misalign}, 0);
        rst = 1'b1;
        cyc();

        // Case 1: SW 0x100, three BUSY cycles before the response
        present(1'b0, 3'b010, 32'h100, 32'hDEADBEEF);
        chk("c1_stall_idle", {31'd0, dside_stall_n}, 0);
        chk("c1_no_early_write", {31'd0, dmem_write}, 0);
        cyc();
        idle_req();
        for (int i = 0; i < 3; i++) begin
            chk("c1_write", {31'd0, dmem_write}, 1);
            chk("c1_read", {31'd0, dmem_read}, 0);
            chk("c1_addr", dmem_address, 32'h100);
            chk("c1_mask", {28'd0, dmem_wmask}, 32'hF);
            chk("c1_wdata", dmem_wdata, 32'hDEADBEEF);
            chk("c1_stall_busy", {31'd0, dside_stall_n}, 0);
            chk("c1_done_busy", {31'd0, done}, 0);
            if (i == 2) dmem_resp = 1'b1;
            cyc();
        end
        dmem_resp = 1'b0;
        chk("c1_done", {31'd0, done}, 1);
        chk("c1_write_drop", {31'd0, dmem_write}, 0);
        chk("c1_stall_done", {31'd0, dside_stall_n}, 1);
        chk("c1_rdata_kept", rdata_o, 0);
        pipe_advance = 1'b1;
        cyc();
        pipe_advance = 1'b0;
        chk("c1_idle_done", {31'd0, done}, 0);

        // Case 2: SB 0x103
        present(1'b0, 3'b000, 32'h103, 32'h000000AB);
        cyc();
        idle_req();
        chk("c2_mask", {28'd0, dmem_wmask}, 32'h8);
        chk("c2_wdata", dmem_wdata, 32'hABABABAB);
        chk("c2_addr", dmem_address, 32'h100);
        dmem_resp = 1'b1;
        cyc();
        dmem_resp = 1'b0;
        chk("c2_done", {31'd0, done}, 1);
        pipe_advance = 1'b1;
        cyc();
        pipe_advance = 1'b0;

        // Case 3: LW 0x200, done held while pipe_advance low
        present(1'b1, 3'b010, 32'h200, 32'h0);
        cyc();
        idle_req();
        chk("c3_read", {31'd0, dmem_read}, 1);
        chk("c3_write", {31'd0, dmem_write}, 0);
        chk("c3_mask", {28'd0, dmem_wmask}, 0);
        chk("c3_addr", dmem_address, 32'h200);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h12345678;
        cyc();
        dmem_resp  = 1'b0;
        dmem_rdata = 32'hFFFF0000;
        for (int i = 0; i < 2; i++) begin
            chk("c3_done_hold", {31'd0, done}, 1);
            chk("c3_rdata_hold", rdata_o, 32'h12345678);
            chk("c3_read_off", {31'd0, dmem_read}, 0);
            cyc();
        end
        pipe_advance = 1'b1;
        chk("c3_done_last", {31'd0, done}, 1);
        cyc();
        pipe_advance = 1'b0;
        chk("c3_idle", {31'd0, done}, 0);
        chk("c3_rdata_after", rdata_o, 32'h12345678);

        // dmem_resp while IDLE is ignored
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h00000055;
        cyc();
        dmem_resp  = 1'b0;
        chk("stray_resp_done", {31'd0, done}, 0);
        chk("stray_resp_rdata", rdata_o, 32'h12345678);

        // Non-memory instruction in IDLE
        req_valid = 1'b1;
        #1;
        chk("nonmem_stall_n", {31'd0, dside_stall_n}, 1);
        cyc();
        req_valid = 1'b0;
        chk("nonmem_read", {31'd0, dmem_read}, 0);
        chk("nonmem_write", {31'd0, dmem_write}, 0);

        // Case 4: reset in the same cycle as the response
        present(1'b1, 3'b010, 32'h300, 32'h0);
        cyc();
        idle_req();
        chk("c4_read", {31'd0, dmem_read}, 1);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        rst        = 1'b0;
        cyc();
        dmem_resp = 1'b0;
        rst       = 1'b1;
        chk("c4_done", {31'd0, done}, 0);
        chk("c4_read_off", {31'd0, dmem_read}, 0);
        chk("c4_addr", dmem_address, 0);
        chk("c4_rdata", rdata_o, 0);
        chk("c4_mask", {28'd0, dmem_wmask}, 0);
        chk("c4_wdata", dmem_wdata, 0);
        chk("c4_stall_n", {31'd0, dside_stall_n}, 1);
        cyc();
        chk("c4_no_done", {31'd0, done}, 0);

        // Case 5: LW then SH 0x202 accepted from DONE
        present(1'b1, 3'b010, 32'h400, 32'h0);
        cyc();
        idle_req();
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h11112222;
        cyc();
        dmem_resp = 1'b0;
        chk("c5_done", {31'd0, done}, 1);
        pipe_advance = 1'b1;
        present(1'b0, 3'b001, 32'h202, 32'h0000BEEF);
        chk("c5_stall_n_done", {31'd0, dside_stall_n}, 1);
        cyc();
        pipe_advance = 1'b0;
        idle_req();
        chk("c5_direct_busy", {31'd0, dmem_write}, 1);
        chk("c5_done_off", {31'd0, done}, 0);
        chk("c5_mask", {28'd0, dmem_wmask}, 32'hC);
        chk("c5_wdata", dmem_wdata, 32'hBEEFBEEF);
        chk("c5_addr", dmem_address, 32'h200);
        dmem_resp = 1'b1;
        cyc();
        dmem_resp = 1'b0;
        chk("c5_done2", {31'd0, done}, 1);
        chk("c5_rdata_kept", rdata_o, 32'h11112222);
        pipe_advance = 1'b1;
        cyc();
        pipe_advance = 1'b0;

        // Misaligned LH 0x201
        present(1'b1, 3'b001, 32'h201, 32'h0);
        cyc();
        idle_req();
`ifdef MISALIGN_TRAP_EN
        chk("c6_no_read", {31'd0, dmem_read}, 0);
        chk("c6_misalign", {31'd0, misalign}, 1);
        chk("c6_done", {31'd0, done}, 1);
        pipe_advance = 1'b1;
        cyc();
        pipe_advance = 1'b0;
        chk("c6_misalign_clr", {31'd0, misalign}, 0);
`else
        chk("mis_read", {31'd0, dmem_read}, 1);
        chk("mis_flag", {31'd0, misalign}, 0);
        chk("mis_addr", dmem_address, 32'h200);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h0A0B0C0D;
        cyc();
        dmem_resp = 1'b0;
        chk("mis_rdata", rdata_o, 32'h0A0B0C0D);
        pipe_advance = 1'b1;
        cyc();
        pipe_advance = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
